// File: rtl/converter_i2f_if.sv
// Strobe/acknowledge bus for converter_i2f: an integer operand goes in and a float result comes out.
// The converter sits on the slave side and the producer/consumer sits on the master side.
interface converter_i2f_if;
  logic [31:0] i_A;
  logic        i_A_STB;
  logic        o_A_ACK;
  logic [31:0] o_Z;
  logic        o_Z_STB;
  logic        i_Z_ACK;

  modport slave (
    input  i_A,
    input  i_A_STB,
    input  i_Z_ACK,
    output o_A_ACK,
    output o_Z,
    output o_Z_STB
  );

  modport master (
    output i_A,
    output i_A_STB,
    output i_Z_ACK,
    input  o_A_ACK,
    input  o_Z,
    input  o_Z_STB
  );
endinterface

// File: rtl/converter_i2f.sv
// Iterative int32 -> IEEE-754 single converter with a strobe/ack handshake.
// Define CONVERTER_I2F_ROUND_EN for round-to-nearest-even; otherwise the result is truncated toward zero.
module converter_i2f (
  input  logic              i_CLK,
  input  logic              i_RST,
  converter_i2f_if.slave    bus
);

  typedef enum logic [2:0] {
    GET_A,
    CONVERT_0,
    NORMALISE,
    ROUND,
    PACK,
    PUT_Z
  } state_t;

  state_t      r_state;
  logic [31:0] r_a;
  logic [31:0] r_v;
  logic [23:0] r_m;
  logic [7:0]  r_e;
  logic        r_s;
  logic [31:0] r_z;
  logic        r_a_ack;
  logic        r_z_stb;
  logic [31:0] r_z_out;

`ifdef CONVERTER_I2F_ROUND_EN
  logic        r_g;
  logic        r_r;
  logic        r_st;
  logic [24:0] w_m_inc;
  logic        w_round_up;

  assign w_m_inc    = {1'b0, r_m} + 25'd1;
  assign w_round_up = r_g && (r_r || r_st || r_m[0]);
`endif

  assign bus.o_A_ACK = r_a_ack;
  assign bus.o_Z_STB = r_z_stb;
  assign bus.o_Z     = r_z_out;

  always_ff @(posedge i_CLK) begin
    if (i_RST) begin
      r_state <= GET_A;
      r_a_ack <= 1'b0;
      r_z_stb <= 1'b0;
      r_z_out <= 32'd0;
      r_a     <= 32'd0;
      r_v     <= 32'd0;
      r_m     <= 24'd0;
      r_e     <= 8'd0;
      r_s     <= 1'b0;
      r_z     <= 32'd0;
`ifdef CONVERTER_I2F_ROUND_EN
      r_g     <= 1'b0;
      r_r     <= 1'b0;
      r_st    <= 1'b0;
`endif
    end else begin
      case (r_state)
        GET_A: begin
          r_a_ack <= 1'b1;
          if (r_a_ack && bus.i_A_STB) begin
            r_a     <= bus.i_A;
            r_a_ack <= 1'b0;
            r_state <= CONVERT_0;
          end
        end

        CONVERT_0: begin
          if (r_a == 32'd0) begin
            r_z     <= 32'd0;
            r_state <= PUT_Z;
          end else begin
            // Negating 0x80000000 wraps to itself, which is the correct magnitude as unsigned.
            r_s     <= r_a[31];
            r_v     <= r_a[31] ? (32'd0 - r_a) : r_a;
            r_e     <= 8'd31;
            r_state <= NORMALISE;
          end
        end

        NORMALISE: begin
          if (!r_v[31]) begin
            r_v <= r_v << 1;
            r_e <= r_e - 8'd1;
          end else begin
            r_m     <= r_v[31:8];
`ifdef CONVERTER_I2F_ROUND_EN
            r_g     <= r_v[7];
            r_r     <= r_v[6];
            r_st    <= |r_v[5:0];
`endif
            r_state <= ROUND;
          end
        end

        ROUND: begin
`ifdef CONVERTER_I2F_ROUND_EN
          if (w_round_up) begin
            // A carry out of the mantissa means it rolled over to the next power of two.
            if (w_m_inc[24]) begin
              r_m <= 24'h800000;
              r_e <= r_e + 8'd1;
            end else begin
              r_m <= w_m_inc[23:0];
            end
          end
`endif
          r_state <= PACK;
        end

        PACK: begin
          r_z[31]    <= r_s;
          r_z[30:23] <= r_e + 8'd127;
          r_z[22:0]  <= r_m[22:0];
          r_state    <= PUT_Z;
        end

        PUT_Z: begin
          r_z_stb <= 1'b1;
          r_z_out <= r_z;
          if (r_z_stb && bus.i_Z_ACK) begin
            r_z_stb <= 1'b0;
            r_state <= GET_A;
          end
        end

        default: begin
          r_state <= GET_A;
          r_a_ack <= 1'b0;
          r_z_stb <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_converter_i2f.sv
// Directed bench for converter_i2f: a vector table of conversions plus backpressure and reset sequences.
// Expected values follow CONVERTER_I2F_ROUND_EN when it is defined.
module tb_converter_i2f;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  converter_i2f_if bus ();

  converter_i2f dut (
    .i_CLK (clk),
    .i_RST (rst),
    .bus   (bus.slave)
  );

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [31:0] a;
    logic [31:0] z;
    int          lat;
    string       name;
  } vec_t;

`ifdef CONVERTER_I2F_ROUND_EN
  localparam logic [31:0] Z_7FFFFFFF = 32'h4F000000;
  localparam logic [31:0] Z_01000003 = 32'h4B800002;
  localparam logic [31:0] Z_02000003 = 32'h4C000001;
`else
  localparam logic [31:0] Z_7FFFFFFF = 32'h4EFFFFFF;
  localparam logic [31:0] Z_01000003 = 32'h4B800001;
  localparam logic [31:0] Z_02000003 = 32'h4C000000;
`endif

  localparam int NVEC = 12;
  vec_t vecs [NVEC];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Waits for o_A_ACK, issues one operand, counts edges until o_Z_STB (E0 = accept edge).
  task automatic start_conv(input string name, input logic [31:0] a, output int lat);
    int n;
    n = 0;
    while (!bus.o_A_ACK && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    chk({name, "_ack_ready"}, {31'd0, bus.o_A_ACK}, 32'd1);
    bus.i_A     = a;
    bus.i_A_STB = 1'b1;
    @(posedge clk); #1;
    bus.i_A_STB = 1'b0;
    bus.i_A     = 32'hDEADBEEF;
    lat = 0;
    while (!bus.o_Z_STB && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  // Completes the output handshake and checks the strobe drop and ack return timing.
  task automatic finish_conv(input string name);
    bus.i_Z_ACK = 1'b1;
    @(posedge clk); #1;
    bus.i_Z_ACK = 1'b0;
    chk({name, "_stb_drop"}, {31'd0, bus.o_Z_STB}, 32'd0);
    chk({name, "_ack_low"},  {31'd0, bus.o_A_ACK}, 32'd0);
    @(posedge clk); #1;
    chk({name, "_ack_back"}, {31'd0, bus.o_A_ACK}, 32'd1);
  endtask

  initial begin
    int lat;

    vecs[0]  = '{32'h00000001, 32'h3F800000,       36, "one"};
    vecs[1]  = '{32'hFFFFFFFF, 32'hBF800000,       36, "minus_one"};
    vecs[2]  = '{32'h00000000, 32'h00000000,        2, "zero"};
    vecs[3]  = '{32'h80000000, 32'hCF000000,        5, "int_min"};
    vecs[4]  = '{32'h7FFFFFFF, Z_7FFFFFFF,          6, "int_max"};
    vecs[5]  = '{32'h01000003, Z_01000003,         12, "tie_odd"};
    vecs[6]  = '{32'h01000001, 32'h4B800000,       12, "tie_even"};
    vecs[7]  = '{32'h00000064, 32'h42C80000,       30, "hundred"};
    vecs[8]  = '{32'hFFFFFF9C, 32'hC2C80000,       30, "minus_hundred"};
    vecs[9]  = '{32'h00FFFFFF, 32'h4B7FFFFF,       13, "exact_24b"};
    vecs[10] = '{32'h01000002, 32'h4B800001,       12, "exact_lsb"};
    vecs[11] = '{32'h02000003, Z_02000003,         11, "round_up"};

    bus.i_A     = 32'd0;
    bus.i_A_STB = 1'b0;
    bus.i_Z_ACK = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    chk("reset_a_ack", {31'd0, bus.o_A_ACK}, 32'd0);
    chk("reset_z_stb", {31'd0, bus.o_Z_STB}, 32'd0);
    chk("reset_z",     bus.o_Z,              32'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("ack_after_reset", {31'd0, bus.o_A_ACK}, 32'd1);

    for (int i = 0; i < NVEC; i++) begin
      start_conv(vecs[i].name, vecs[i].a, lat);
      chk_int({vecs[i].name, "_latency"}, lat, vecs[i].lat);
      chk({vecs[i].name, "_z"}, bus.o_Z, vecs[i].z);
      finish_conv(vecs[i].name);
      $display("vec %0d %s a=%08h z=%08h lat=%0d", i, vecs[i].name, vecs[i].a, bus.o_Z, lat);
    end

    // Backpressure: result must hold for 20 cycles while a stray operand strobe is ignored.
    start_conv("bp", 32'h00000064, lat);
    chk_int("bp_latency", lat, 30);
    for (int k = 0; k < 20; k++) begin
      bus.i_A     = 32'h00000005;
      bus.i_A_STB = (k % 3 == 0);
      @(posedge clk); #1;
      chk("bp_stb_hold", {31'd0, bus.o_Z_STB}, 32'd1);
      chk("bp_z_hold",   bus.o_Z,              32'h42C80000);
      chk("bp_a_ack",    {31'd0, bus.o_A_ACK}, 32'd0);
    end
    bus.i_A_STB = 1'b0;
    finish_conv("bp");
    $display("seq backpressure z=%08h", bus.o_Z);

    // Reset during normalise discards the conversion in flight.
    start_conv("rst_pre", 32'h00000001, lat);
    finish_conv("rst_pre");
    bus.i_A     = 32'h00000001;
    bus.i_A_STB = 1'b1;
    @(posedge clk); #1;
    bus.i_A_STB = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("midrst_z_stb", {31'd0, bus.o_Z_STB}, 32'd0);
    chk("midrst_a_ack", {31'd0, bus.o_A_ACK}, 32'd0);
    @(posedge clk); #1;
    chk("midrst_ack_rise", {31'd0, bus.o_A_ACK}, 32'd1);
    start_conv("post_rst", 32'h00000064, lat);
    chk_int("post_rst_latency", lat, 30);
    chk("post_rst_z", bus.o_Z, 32'h42C80000);
    finish_conv("post_rst");
    $display("seq midreset z=%08h lat=%0d", bus.o_Z, lat);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
